// File: rtl/forward_hazard_ctrl_pkg.sv
// Shared types and constants for the forwarding / hazard control block:
// forwarding mux encodings, mult/div occupancy FSM states, default MD_LAT
// and small helpers used by the hazard comparators.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE    = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int unsigned MD_LAT_DEFAULT = 32;

  // True when a pipeline stage with destination rd and write enable we
  // produces the (non-r0) source register src.
  function automatic logic producer_hit(input logic [4:0] src,
                                        input logic [4:0] rd,
                                        input logic       we);
    return we && (rd != '0) && (rd == src);
  endfunction

  // EX/MEM is the younger producer, so it takes priority over MEM/WB.
  function automatic fwd_sel_e fwd_select(input logic [4:0] src,
                                          input logic [4:0] mem_rd,
                                          input logic       mem_regwrite,
                                          input logic [4:0] wb_rd,
                                          input logic       wb_regwrite);
    if (producer_hit(src, mem_rd, mem_regwrite)) return FWD_MEM;
    if (producer_hit(src, wb_rd, wb_regwrite))   return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/forward_hazard_ctrl_if.sv
// Pipeline-side bundle for the forwarding / hazard control block.
// master: the pipeline datapath (drives register ids, sees selects/stalls).
// slave : the hazard control block.
interface forward_hazard_ctrl_if;

  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_md_start;
  logic [4:0] ex_rs;
  logic [4:0] ex_rt;
  logic [4:0] ex_rd;
  logic       ex_regwrite;
  logic       ex_memread;
  logic [4:0] mem_rd;
  logic       mem_regwrite;
  logic [4:0] wb_rd;
  logic       wb_regwrite;
  logic       branch_taken;

  logic [1:0] fwd_a;
  logic [1:0] fwd_b;
  logic       pc_stall;
  logic       ifid_stall;
  logic       ifid_flush;
  logic       idex_flush;
  logic       md_busy;

  modport master (
    output id_rs, id_rt, id_md_start, ex_rs, ex_rt, ex_rd, ex_regwrite,
           ex_memread, mem_rd, mem_regwrite, wb_rd, wb_regwrite, branch_taken,
    input  fwd_a, fwd_b, pc_stall, ifid_stall, ifid_flush, idex_flush, md_busy
  );

  modport slave (
    input  id_rs, id_rt, id_md_start, ex_rs, ex_rt, ex_rd, ex_regwrite,
           ex_memread, mem_rd, mem_regwrite, wb_rd, wb_regwrite, branch_taken,
    output fwd_a, fwd_b, pc_stall, ifid_stall, ifid_flush, idex_flush, md_busy
  );

endinterface

// File: rtl/forward_hazard_ctrl_md_occupancy_ctr.sv
// Mult/div occupancy tracker: once started, holds md_busy high for exactly
// MD_LAT cycles using a down-counter loaded with MD_LAT-1.
module md_occupancy_ctr
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LAT = MD_LAT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic md_busy
);

  md_state_e  state, state_nxt;
  logic [5:0] cnt, cnt_nxt;

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state: load on accept, count down while busy, leave after cnt==0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = 6'(MD_LAT - 1);
        end
      end
      MD_BUSY: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 6'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign md_busy = (state == MD_BUSY);

endmodule

// File: rtl/forward_hazard_ctrl.sv
// Forwarding-select and hazard (stall / flush) control for a 5-stage pipe,
// including mult/div occupancy interlock.
// Optional feature macro: FORWARD_PATH_EN
//   defined   -> EX/MEM and MEM/WB forwarding, load-use bubble only.
//   undefined -> no forwarding; stall on any EX or MEM producer match.
module forward_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MD_LAT = MD_LAT_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  forward_hazard_ctrl_if.slave hz
);

  logic     md_busy;
  logic     data_stall;
  logic     md_stall;
  logic     md_start;
  logic     stall;
  fwd_sel_e fwd_a_sel;
  fwd_sel_e fwd_b_sel;

`ifdef FORWARD_PATH_EN
  // Operand forwarding plus load-use detection (loaded data not yet available).
  always_comb begin
    fwd_a_sel  = fwd_select(hz.ex_rs, hz.mem_rd, hz.mem_regwrite, hz.wb_rd, hz.wb_regwrite);
    fwd_b_sel  = fwd_select(hz.ex_rt, hz.mem_rd, hz.mem_regwrite, hz.wb_rd, hz.wb_regwrite);
    data_stall = hz.ex_memread && (hz.ex_rd != '0) &&
                 ((hz.ex_rd == hz.id_rs) || (hz.ex_rd == hz.id_rt));
  end

  logic unused_sigs;
  assign unused_sigs = hz.ex_regwrite;
`else
  // Without forwarding, any in-flight EX or MEM producer of an ID source must
  // drain; WB needs no stall since the regfile writes before it is read.
  always_comb begin
    fwd_a_sel  = FWD_RF;
    fwd_b_sel  = FWD_RF;
    data_stall = producer_hit(hz.id_rs, hz.ex_rd,  hz.ex_regwrite)  ||
                 producer_hit(hz.id_rt, hz.ex_rd,  hz.ex_regwrite)  ||
                 producer_hit(hz.id_rs, hz.mem_rd, hz.mem_regwrite) ||
                 producer_hit(hz.id_rt, hz.mem_rd, hz.mem_regwrite);
  end

  logic unused_sigs;
  assign unused_sigs = ^{hz.ex_rs, hz.ex_rt, hz.ex_memread, hz.wb_rd, hz.wb_regwrite};
`endif

  // A new mult/div waits in ID while the unit is occupied; it is accepted only
  // from IDLE and only if the instruction is actually leaving ID this cycle.
  assign md_stall = hz.id_md_start && md_busy;
  assign md_start = hz.id_md_start && !md_busy && !data_stall && !hz.branch_taken;

  md_occupancy_ctr #(
    .MD_LAT (MD_LAT)
  ) u_md_occupancy_ctr (
    .clk     (clk),
    .rst     (rst),
    .start   (md_start),
    .md_busy (md_busy)
  );

  // Output drive: a taken branch flushes and overrides any stall; reset
  // silences all stall/flush/forward outputs.
  always_comb begin
    stall         = (data_stall || md_stall) && !hz.branch_taken;
    hz.fwd_a      = FWD_RF;
    hz.fwd_b      = FWD_RF;
    hz.pc_stall   = 1'b0;
    hz.ifid_stall = 1'b0;
    hz.ifid_flush = 1'b0;
    hz.idex_flush = 1'b0;
    hz.md_busy    = md_busy;
    if (!rst) begin
      hz.fwd_a      = fwd_a_sel;
      hz.fwd_b      = fwd_b_sel;
      hz.pc_stall   = stall;
      hz.ifid_stall = stall;
      hz.ifid_flush = hz.branch_taken;
      hz.idex_flush = stall || hz.branch_taken;
    end
  end

endmodule
